// File: rtl/calculadora_bcd.sv
// calculadora_bcd: unsigned accumulator calculator with a sequential BCD display path.
//
// Rising edges on somar/subtrair/zerar add, subtract or clear the accumulator.
// The display path runs a free-running double-dabble conversion. The source is either the
// operand or the accumulator. Each finished conversion is registered onto active-low
// seven-segment digits.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   entrada     unsigned operand (WIDTH bits)
//   mostrar     level: 1 shows entrada, 0 shows the accumulator
//   somar       rising edge: acc += entrada
//   subtrair    rising edge: acc -= entrada
//   zerar       rising edge: acc = 0, estouro = 0
//   digitos     NDIG digits, digit i at [7i+6:7i], gfedcba, active-low
//   acumulador  current accumulator value
//   estouro     sticky wrap flag
//   pronto      one-cycle pulse when digitos updates
module calculadora_bcd #(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned ACC_WIDTH   = 19,
  parameter int unsigned NDIG        = 6,
  parameter int unsigned BLANK_ZEROS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       entrada,
  input  logic                   mostrar,
  input  logic                   somar,
  input  logic                   subtrair,
  input  logic                   zerar,
  output logic [7*NDIG-1:0]      digitos,
  output logic [ACC_WIDTH-1:0]   acumulador,
  output logic                   estouro,
  output logic                   pronto
);

  localparam int unsigned BcdW = 4 * NDIG;
  localparam int unsigned CntW = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACC_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Command edge detection
  // ---------------------------------------------------------------------------
  // Previous-value registers reset to 1 so an input held high through reset does not fire.
  logic somar_prev_q, subtrair_prev_q, zerar_prev_q;
  logic fire_somar, fire_subtrair, fire_zerar;

  always_ff @(posedge clk) begin
    if (reset) begin
      somar_prev_q    <= 1'b1;
      subtrair_prev_q <= 1'b1;
      zerar_prev_q    <= 1'b1;
    end else begin
      somar_prev_q    <= somar;
      subtrair_prev_q <= subtrair;
      zerar_prev_q    <= zerar;
    end
  end

  assign fire_somar    = somar & ~somar_prev_q;
  assign fire_subtrair = subtrair & ~subtrair_prev_q;
  assign fire_zerar    = zerar & ~zerar_prev_q;

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 estouro_q, estouro_d;
  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH:0]   sum;

  assign operand = ACC_WIDTH'(entrada);
  assign sum     = {1'b0, acc_q} + {1'b0, operand};

  // zerar > somar > subtrair; lower-priority edges in the same cycle are dropped.
  always_comb begin
    acc_d     = acc_q;
    estouro_d = estouro_q;
    if (fire_zerar) begin
      acc_d     = '0;
      estouro_d = 1'b0;
    end else if (fire_somar) begin
      acc_d = sum[ACC_WIDTH-1:0];
      if (sum[ACC_WIDTH]) begin
        estouro_d = 1'b1;
      end
    end else if (fire_subtrair) begin
      acc_d = acc_q - operand;
      if (operand > acc_q) begin
        estouro_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      estouro_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      estouro_q <= estouro_d;
    end
  end

  assign acumulador = acc_q;
  assign estouro    = estouro_q;

  // ---------------------------------------------------------------------------
  // Double-dabble conversion FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StLoad, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]       bcd_q, bcd_d;
  logic [BcdW-1:0]       bcd_adj;
  logic [BcdW+ACC_WIDTH-1:0] shifted;
  logic [7*NDIG-1:0]     digitos_q, digitos_d;
  logic [7*NDIG-1:0]     digitos_rst;
  logic [7*NDIG-1:0]     seg_next;
  logic                  pronto_q, pronto_d;
  logic [ACC_WIDTH-1:0]  source;

  assign source = mostrar ? operand : acc_q;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction on every nibble that would exceed 9 after the shift.
  always_comb begin
    logic [3:0] nib;
    nib     = '0;
    bcd_adj = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      nib = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  // Segment patterns for the finished BCD value, blanking leading zeros from the top down.
  always_comb begin
    logic [3:0] nib;
    logic       zero_above;
    nib        = '0;
    zero_above = 1'b1;
    seg_next   = '0;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      if ((BLANK_ZEROS != 0) && (i > 0) && zero_above && (nib == 4'd0)) begin
        seg_next[7*i +: 7] = 7'b1111111;
      end else begin
        seg_next[7*i +: 7] = seg_encode(nib);
      end
      zero_above = zero_above & (nib == 4'd0);
    end
  end

  // Display after reset: a single "0" in digit 0.
  always_comb begin
    digitos_rst = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if ((i == 0) || (BLANK_ZEROS == 0)) begin
        digitos_rst[7*i +: 7] = 7'b1000000;
      end else begin
        digitos_rst[7*i +: 7] = 7'b1111111;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    digitos_d = digitos_q;
    pronto_d  = 1'b0;
    unique case (state_q)
      StLoad: begin
        bin_d   = source;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d = shifted[BcdW+ACC_WIDTH-1:ACC_WIDTH];
        bin_d = shifted[ACC_WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        digitos_d = seg_next;
        pronto_d  = 1'b1;
        state_d   = StLoad;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StLoad;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      digitos_q <= digitos_rst;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      digitos_q <= digitos_d;
      pronto_q  <= pronto_d;
    end
  end

  assign digitos = digitos_q;
  assign pronto  = pronto_q;

endmodule

// File: doc/calculadora_bcd.md
# calculadora_bcd

Parametrised successor of the lab04 accumulator calculator: an unsigned accumulator with edge-triggered add, subtract and clear commands, a sticky overflow flag, and a six-digit (by default) active-low seven-segment output. Binary-to-BCD conversion runs in a sequential double-dabble engine instead of combinational dividers. The block sits between the board switches/keys and the HEX displays.

## Interface
Parameters:
- WIDTH, 10, width of `entrada`.
- ACC_WIDTH, 19, accumulator width. Must satisfy WIDTH ≤ ACC_WIDTH and 2^ACC_WIDTH−1 ≤ 10^NDIG−1.
- NDIG, 6, number of decimal digits driven.
- BLANK_ZEROS, 1, if 1, leading-zero digits are blanked. Digit 0 is never blanked.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- entrada  in  WIDTH  unsigned operand.
- mostrar  in  1  level. 1 displays `entrada`, 0 displays the accumulator.
- somar  in  1  rising edge adds `entrada` to the accumulator.
- subtrair  in  1  rising edge subtracts `entrada` from the accumulator.
- zerar  in  1  rising edge clears the accumulator and `estouro`.
- digitos  out  7*NDIG  segments. Digit i is at [7i+6:7i], bit order g..a, active-low.
- acumulador  out  ACC_WIDTH  current accumulator value.
- estouro  out  1  sticky wrap flag.
- pronto  out  1  one-cycle pulse when `digitos` updates.

## Operation
- **Edge detection:** each of somar, subtrair and zerar has a previous-value register. A command fires on the cycle where input=1 and prev=0. Holding an input high fires exactly once.
- **Priority** when several commands fire in the same cycle: zerar > somar > subtrair. Lower-priority edges in that cycle are discarded.
- **somar:** acc ← (acc + entrada) mod 2^ACC_WIDTH. If the carry-out is set, estouro ← 1.
- **subtrair:** acc ← (acc − entrada) mod 2^ACC_WIDTH. If entrada > acc, estouro ← 1.
- **zerar:** acc ← 0 and estouro ← 0.
- **Operand:** `entrada` is zero-extended to ACC_WIDTH and is sampled in the cycle the edge is detected.
- **Conversion FSM:** runs continuously and is independent of the command logic.
  - LOAD (1 cycle): captures the source, which is mostrar ? zero-extended entrada : acc. Clears the 4·NDIG BCD scratch register.
  - SHIFT (ACC_WIDTH cycles): each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left by 1.
  - DONE (1 cycle): registers the seven-segment encodings into `digitos`, pulses `pronto`, then goes to LOAD.
- **Conversion period:** ACC_WIDTH+2 cycles (21 with defaults).
- **Blanking** (BLANK_ZEROS=1): digit i>0 is blank (7'b1111111) if it and all higher digits are 0.
- **Encoding, active-low gfedcba:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- **Source changes mid-conversion:** any change to the source during SHIFT is ignored until the next LOAD. `digitos` never shows a partially converted value.

## Timing
- **Reset values:**
  - acc=0, estouro=0, pronto=0, FSM=LOAD.
  - `digitos` = digit0 "0" (1000000). Other digits are blank, or 1000000 if BLANK_ZEROS=0.
  - Edge prev registers reset to 1, so an input already held high through reset does not fire.
- **Command latency:** `acumulador`/`estouro` update at the clock edge that first samples the input high (1 cycle).
- **Display latency:** from an acc or source change to `digitos` reflecting it, at most 2·(ACC_WIDTH+2) cycles (≤ 42 with defaults).
- **pronto:** high for exactly 1 cycle per conversion. Spacing between pulses is exactly ACC_WIDTH+2 cycles.
- **Reset mid-conversion:** the scratch register is discarded, and all outputs return to their reset values on the next edge.
- **Commands during conversion:** always accepted. They affect only the next LOAD.

## Test plan
- **Reset and display:** reset 3 cycles, release → `digitos` shows "0" with 5 blanks, acc=0, estouro=0. `pronto` pulses every 21 cycles.
- **Add then display:** entrada=10, mostrar=0, somar high 4 cycles → acc=10, a single add only. Within 42 cycles digit1=1111001, digit0=1000000, digits 5..2 blank.
- **Subtract and underflow:**
  - From acc=10: entrada=5, subtrair pulse → acc=5, digit0=0010010.
  - Then entrada=6, subtrair pulse → acc=524287, estouro=1, display "524287".
  - zerar pulse → acc=0, estouro=0.
- **Overflow wrap:** acc=524287, entrada=1, somar → acc=0, estouro=1. A further somar with entrada=3 → acc=3 and estouro stays 1.
- **Simultaneous commands:** somar, subtrair and zerar rise in the same cycle with acc=7 → acc=0. somar and subtrair rise together with entrada=4, acc=0 → acc=4.
- **mostrar and reset mid-conversion:**
  - mostrar=1, entrada=1023 → display "1023" while acc remains unchanged.
  - reset asserted in the middle of SHIFT → the next cycle shows reset values, with no stale `pronto`.
